pipeline_stall_ctrl: RTL and testbench

Sequential hazard controller for the 5-stage MIPS pipeline; complements the EXE-stage forwarding unit by handling the hazards forwarding cannot resolve. Generates stall and flush controls for the IF/ID and ID/EXE pipeline registers on load-use hazards and decode-stage branch-compare hazards. Owns the busy sequencing of the multi-cycle multiply/divide unit (MDU), so that HI/LO consumers and new MDU ops wait in decode until the MDU is free.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 34 +++
 rtl/pipeline_stall_ctrl_mdu_busy_counter.sv | 81 ++++++++
 rtl/pipeline_stall_ctrl.sv | 109 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_pkg
// Shared definitions for the 5-stage MIPS pipeline hazard logic: forwarding
// select encodings (used by the EXE-stage forwarding unit), the MDU busy-state
// enum and default multiply/divide latencies used by pipeline_stall_ctrl.
// -----------------------------------------------------------------------------
package pipeline_hazard_ctrl_pkg;

  // Forwarding mux select for an EXE-stage ALU operand.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,  // operand from the ID/EXE register
    FWD_WB   = 2'b01,  // operand from the writeback result
    FWD_MEM  = 2'b10   // operand from the DM-stage ALU result
  } fwd_sel_e;

  // Multi-cycle multiply/divide unit sequencing.
  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  localparam int MULT_LAT_DEF = 4;
  localparam int DIV_LAT_DEF  = 32;
  localparam int CNT_W_DEF    = 6;

  // True when a producing stage's destination feeds either decode source.
  // Register 0 is hard-wired to zero, so it never creates a dependency.
  function automatic logic src_match(input logic [4:0] dst,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (dst != 5'd0) && ((dst == rs) || (dst == rt));
  endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_mdu_busy_counter.sv
// -----------------------------------------------------------------------------
// mdu_busy_counter
// Busy sequencer for the multi-cycle multiply/divide unit. A start sampled on
// rising edge N makes busy high for cycles N+1 .. N+LAT, with done high in the
// final busy cycle only. A start while busy is ignored (decode stalls keep it
// from happening). Reset aborts an operation without a done pulse.
//
// Ports:
//   clk    in  pipeline clock
//   rst_n  in  asynchronous active-low reset
//   start  in  mult/div issued in EXE this cycle
//   div    in  qualifies start: 1 = divide, 0 = multiply
//   busy   out operation in progress
//   done   out one-cycle pulse in the final busy cycle
// -----------------------------------------------------------------------------
module mdu_busy_counter
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic done
);

  // The counter holds the number of busy cycles still to follow the current
  // one, so it is loaded with LAT-1 and the last busy cycle sees zero.
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      MDU_IDLE: begin
        if (start) begin
          state_d = MDU_BUSY;
          cnt_d   = div ? DIV_LOAD : MULT_LOAD;
        end
      end
      MDU_BUSY: begin
        if (cnt_q == '0) begin
          state_d = MDU_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == MDU_BUSY);
    done = (state_q == MDU_BUSY) && (cnt_q == '0);
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
// Hazard controller for the 5-stage MIPS pipeline. Covers what the EXE-stage
// forwarding unit cannot: load-use hazards, hazards on operands of branches
// compared in ID, and waits on the multi-cycle multiply/divide unit (MDU).
// A stall holds PC and IF/ID and inserts a bubble into ID/EXE; a taken
// branch/jump flushes IF/ID unless the branch itself is stalled.
//
// Build option: define MDU_STALL_EN to build the MDU busy sequencer and the
// MDU stall term. Without it mdu_busy/mdu_done are 0 and mdu_* inputs are
// ignored (ports kept for a fixed interface).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   rs_dec, rt_dec          ID source registers
//   branch_dec              ID instruction is a branch compared in ID
//   pc_src_dec              ID branch/jump is taken
//   mdu_use_dec             ID instruction is mult/div/mfhi/mflo/mthi/mtlo
//   wreg_dst_exe            EXE destination register
//   reg_we_exe              EXE instruction writes the register file
//   mem_to_reg_exe          EXE instruction is a load
//   wreg_dst_dm             DM destination register
//   mem_to_reg_dm           DM instruction is a load
//   mdu_start_exe           mult/div issued in EXE this cycle
//   mdu_div_exe             1 = divide, 0 = multiply
//   stall_fetch, stall_dec  hold PC / IF/ID
//   flush_dec, flush_exe    clear IF/ID / ID/EXE
//   mdu_busy, mdu_done      MDU in progress / final busy cycle pulse
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] rs_dec,
  input  logic [4:0] rt_dec,
  input  logic       branch_dec,
  input  logic       pc_src_dec,
  input  logic       mdu_use_dec,
  input  logic [4:0] wreg_dst_exe,
  input  logic       reg_we_exe,
  input  logic       mem_to_reg_exe,
  input  logic [4:0] wreg_dst_dm,
  input  logic       mem_to_reg_dm,
  input  logic       mdu_start_exe,
  input  logic       mdu_div_exe,
  output logic       stall_fetch,
  output logic       stall_dec,
  output logic       flush_dec,
  output logic       flush_exe,
  output logic       mdu_busy,
  output logic       mdu_done
);

  logic lw_stall;
  logic br_stall;
  logic mdu_stall;
  logic stall;

`ifdef MDU_STALL_EN
  mdu_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_mdu_busy_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mdu_start_exe),
    .div   (mdu_div_exe),
    .busy  (mdu_busy),
    .done  (mdu_done)
  );

  // An op issuing in EXE this cycle is not yet visible in mdu_busy, so it
  // must block a following HI/LO consumer too.
  assign mdu_stall = mdu_use_dec && (mdu_busy || mdu_start_exe);
`else
  localparam int unused_lat = MULT_LAT + DIV_LAT + CNT_W;
  logic unused_mdu;

  assign unused_mdu = ^{clk, rst_n, mdu_start_exe, mdu_div_exe, mdu_use_dec};
  assign mdu_busy   = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_stall  = 1'b0;
`endif

  // A load result is only available after DM, so an ID consumer must wait
  // one cycle even with forwarding.
  assign lw_stall = mem_to_reg_exe && src_match(wreg_dst_exe, rs_dec, rt_dec);

  // Branches compare in ID, before the EXE forwarding point: any pending ALU
  // result in EXE or load result in DM must land first.
  assign br_stall = branch_dec &&
                    ((reg_we_exe    && src_match(wreg_dst_exe, rs_dec, rt_dec)) ||
                     (mem_to_reg_dm && src_match(wreg_dst_dm,  rs_dec, rt_dec)));

  assign stall = lw_stall || br_stall || mdu_stall;

  assign stall_fetch = stall;
  assign stall_dec   = stall;
  assign flush_exe   = stall;
  // A stalled branch has not resolved yet; flushing would drop its successor.
  assign flush_dec   = pc_src_dec && !stall;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
module tb_pipeline_stall_ctrl;

  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 32;
  localparam int CNT_W    = 6;

`ifdef MDU_STALL_EN
  localparam bit MDU_EN = 1'b1;
`else
  localparam bit MDU_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs_dec, rt_dec, wreg_dst_exe, wreg_dst_dm;
  logic       branch_dec, pc_src_dec, mdu_use_dec;
  logic       reg_we_exe, mem_to_reg_exe, mem_to_reg_dm;
  logic       mdu_start_exe, mdu_div_exe;
  logic       stall_fetch, stall_dec, flush_dec, flush_exe, mdu_busy, mdu_done;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string tag;
    logic  stall;
    logic  flush;
    logic  busy;
    logic  done;
  } exp_t;

  exp_t sb_q[$];

  // Reference MDU model: number of busy cycles remaining including this one.
  int busy_left = 0;

  pipeline_stall_ctrl #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs_dec         (rs_dec),
    .rt_dec         (rt_dec),
    .branch_dec     (branch_dec),
    .pc_src_dec     (pc_src_dec),
    .mdu_use_dec    (mdu_use_dec),
    .wreg_dst_exe   (wreg_dst_exe),
    .reg_we_exe     (reg_we_exe),
    .mem_to_reg_exe (mem_to_reg_exe),
    .wreg_dst_dm    (wreg_dst_dm),
    .mem_to_reg_dm  (mem_to_reg_dm),
    .mdu_start_exe  (mdu_start_exe),
    .mdu_div_exe    (mdu_div_exe),
    .stall_fetch    (stall_fetch),
    .stall_dec      (stall_dec),
    .flush_dec      (flush_dec),
    .flush_exe      (flush_exe),
    .mdu_busy       (mdu_busy),
    .mdu_done       (mdu_done)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic dep(input logic [4:0] dst);
    return (dst != 5'd0) && (dst == rs_dec || dst == rt_dec);
  endfunction

  function automatic exp_t model_expect(input string tag);
    exp_t e;
    logic lw, br, md;
    lw = mem_to_reg_exe && dep(wreg_dst_exe);
    br = branch_dec && ((reg_we_exe && dep(wreg_dst_exe)) ||
                        (mem_to_reg_dm && dep(wreg_dst_dm)));
    md = MDU_EN && mdu_use_dec && (busy_left > 0 || mdu_start_exe);
    e.tag   = tag;
    e.stall = lw || br || md;
    e.flush = pc_src_dec && !e.stall;
    e.busy  = busy_left > 0;
    e.done  = busy_left == 1;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    e = sb_q.pop_front();
    check({e.tag, ".stall_fetch"}, stall_fetch, e.stall);
    check({e.tag, ".stall_dec"},   stall_dec,   e.stall);
    check({e.tag, ".flush_exe"},   flush_exe,   e.stall);
    check({e.tag, ".flush_dec"},   flush_dec,   e.flush);
    check({e.tag, ".mdu_busy"},    mdu_busy,    e.busy);
    check({e.tag, ".mdu_done"},    mdu_done,    e.done);
  endtask

  task automatic model_tick();
    if (!rst_n) begin
      busy_left = 0;
    end else if (busy_left > 0) begin
      busy_left--;
    end else if (MDU_EN && mdu_start_exe) begin
      busy_left = mdu_div_exe ? DIV_LAT : MULT_LAT;
    end
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic step(input string tag);
    sb_q.push_back(model_expect(tag));
    @(negedge clk);
    compare_out();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic clear_inputs();
    rs_dec = 5'd0; rt_dec = 5'd0; wreg_dst_exe = 5'd0; wreg_dst_dm = 5'd0;
    branch_dec = 1'b0; pc_src_dec = 1'b0; mdu_use_dec = 1'b0;
    reg_we_exe = 1'b0; mem_to_reg_exe = 1'b0; mem_to_reg_dm = 1'b0;
    mdu_start_exe = 1'b0; mdu_div_exe = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    #1;
    step("reset");
    rst_n = 1'b1;
    step("idle");

    // Load-use: stall exactly one cycle, then the load moves on to DM.
    mem_to_reg_exe = 1'b1; wreg_dst_exe = 5'd8; rs_dec = 5'd8; rt_dec = 5'd3;
    step("lw_rs");
    mem_to_reg_exe = 1'b0; mem_to_reg_dm = 1'b1; wreg_dst_dm = 5'd8; wreg_dst_exe = 5'd0;
    step("lw_after");
    clear_inputs();
    mem_to_reg_exe = 1'b1; wreg_dst_exe = 5'd0;
    step("lw_r0");
    mem_to_reg_exe = 1'b1; wreg_dst_exe = 5'd17; rs_dec = 5'd2; rt_dec = 5'd17;
    step("lw_rt");
    clear_inputs();

    // Branch hazards.
    branch_dec = 1'b1; pc_src_dec = 1'b1; rt_dec = 5'd9; rs_dec = 5'd1;
    reg_we_exe = 1'b1; wreg_dst_exe = 5'd9;
    step("br_exe");
    reg_we_exe = 1'b0; wreg_dst_exe = 5'd0; wreg_dst_dm = 5'd9;
    step("br_resolved");
    mem_to_reg_dm = 1'b1; wreg_dst_dm = 5'd1;
    step("br_dm_load");
    clear_inputs();
    branch_dec = 1'b1; pc_src_dec = 1'b1; reg_we_exe = 1'b1; wreg_dst_exe = 5'd0;
    step("br_r0");
    clear_inputs();
    pc_src_dec = 1'b1;
    step("jump");
    clear_inputs();

    // Divide with mfhi waiting in ID.
    mdu_start_exe = 1'b1; mdu_div_exe = 1'b1; mdu_use_dec = 1'b1;
    step("div_start");
    mdu_start_exe = 1'b0; mdu_div_exe = 1'b0;
    for (int i = 1; i <= DIV_LAT; i++) begin
      if (i == 5) begin
        // Load-use and MDU stall together, with a taken jump: one stall.
        mem_to_reg_exe = 1'b1; wreg_dst_exe = 5'd4; rs_dec = 5'd4; pc_src_dec = 1'b1;
      end else begin
        mem_to_reg_exe = 1'b0; wreg_dst_exe = 5'd0; rs_dec = 5'd0; pc_src_dec = 1'b0;
      end
      step($sformatf("div_busy%0d", i));
    end
    step("div_mfhi_go");
    clear_inputs();
    step("div_idle");

    // Back-to-back multiplies: second held in ID, then issues after the first.
    mdu_start_exe = 1'b1; mdu_use_dec = 1'b1;
    step("mul1_start");
    mdu_start_exe = 1'b0;
    for (int i = 1; i <= MULT_LAT; i++) step($sformatf("mul1_busy%0d", i));
    step("mul2_leave_id");
    mdu_use_dec = 1'b0; mdu_start_exe = 1'b1;
    step("mul2_start");
    mdu_start_exe = 1'b0;
    for (int i = 1; i <= MULT_LAT; i++) step($sformatf("mul2_busy%0d", i));
    step("mul2_idle");

    // Reset during cycle 10 of a divide.
    mdu_start_exe = 1'b1; mdu_div_exe = 1'b1;
    step("div2_start");
    mdu_start_exe = 1'b0; mdu_div_exe = 1'b0;
    for (int i = 1; i <= 9; i++) step($sformatf("div2_busy%0d", i));
    #2;
    rst_n = 1'b0;
    busy_left = 0;
    #1;
    sb_q.push_back(model_expect("rst_abort"));
    compare_out();
    @(posedge clk);
    #1;
    step("rst_hold");
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step($sformatf("post_rst%0d", i));

    // Start then consumer: stalls only when the MDU sequencer is built.
    mdu_start_exe = 1'b1;
    step("cfg_start");
    mdu_start_exe = 1'b0; mdu_use_dec = 1'b1;
    step("cfg_use");
    clear_inputs();
    for (int i = 0; i < MULT_LAT; i++) step($sformatf("cfg_tail%0d", i));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
